// File: rtl/ciphertext_store_memory.sv
// Ciphertext store: captures AES core output words at the plaintext fetch index and serves a registered read port.
// Optional build macro CT_STORE_CHECKSUM_EN adds checksum_o, a running XOR of the words accepted in the current run.
module ciphertext_store_memory #(
    parameter int TEXT_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEMORY_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic                  ct_valid_i,
    input  logic [TEXT_WIDTH-1:0] ct_i,
    output logic                  ct_ready_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  done_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [TEXT_WIDTH-1:0] ciphertext_q
`ifdef CT_STORE_CHECKSUM_EN
    ,
    output logic [TEXT_WIDTH-1:0] checksum_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEMORY_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(MEMORY_SIZE);

    state_t                state_q;
    logic [TEXT_WIDTH-1:0] mem [MEMORY_SIZE];
    logic                  wr_en;
    logic                  rd_in_range;

    // Ready depends only on the state register, so the AES core never sees an input-to-ready path.
    assign ct_ready_o  = (state_q == CAPTURE);
    // Clear (and reset) outrank a coincident handshake: that word is dropped.
    assign wr_en       = ct_ready_o && ct_valid_i && !clear_i && !rst_i;
    assign rd_in_range = ({1'b0, rd_addr_i} < FULL_COUNT);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q   <= IDLE;
            wr_addr_o <= '0;
            count_o   <= '0;
            done_o    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q   <= CAPTURE;
                        wr_addr_o <= '0;
                        count_o   <= '0;
                        done_o    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (ct_valid_i) begin
                        if (wr_addr_o == LAST_ADDR) begin
                            state_q   <= DONE;
                            wr_addr_o <= '0;
                            count_o   <= FULL_COUNT;
                            done_o    <= 1'b1;
                        end else begin
                            wr_addr_o <= wr_addr_o + ADDR_WIDTH'(1);
                            count_o   <= count_o + (ADDR_WIDTH + 1)'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; contents survive rst_i and clear_i.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr_o] <= ct_i;
        end
    end

    // Same-address read and write in one cycle returns the old word, since the array updates after sampling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ciphertext_q <= '0;
        end else if (rd_in_range) begin
            ciphertext_q <= mem[rd_addr_i];
        end else begin
            ciphertext_q <= '0;
        end
    end

`ifdef CT_STORE_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            checksum_o <= '0;
        end else if ((state_q == IDLE || state_q == DONE) && start_i) begin
            checksum_o <= '0;
        end else if (wr_en) begin
            checksum_o <= checksum_o ^ ct_i;
        end
    end
`endif

endmodule

// File: tb/tb_ciphertext_store_memory.sv
// Self-checking bench for ciphertext_store_memory: directed scenarios plus random traffic against a run-level model.
// Define CT_STORE_CHECKSUM_EN for both files to also cover checksum_o.
module tb_ciphertext_store_memory;

    localparam int TW = 128;
    localparam int AW = 4;
    localparam int MS = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          clear_i;
    logic          ct_valid_i;
    logic [TW-1:0] ct_i;
    logic          ct_ready_o;
    logic [AW-1:0] wr_addr_o;
    logic [AW:0]   count_o;
    logic          done_o;
    logic [AW-1:0] rd_addr_i;
    logic [TW-1:0] ciphertext_q;
`ifdef CT_STORE_CHECKSUM_EN
    logic [TW-1:0] checksum_o;
`endif

    always #5 clk_i = ~clk_i;

    ciphertext_store_memory #(
        .TEXT_WIDTH (TW),
        .ADDR_WIDTH (AW),
        .MEMORY_SIZE(MS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .ct_valid_i  (ct_valid_i),
        .ct_i        (ct_i),
        .ct_ready_o  (ct_ready_o),
        .wr_addr_o   (wr_addr_o),
        .count_o     (count_o),
        .done_o      (done_o),
        .rd_addr_i   (rd_addr_i),
        .ciphertext_q(ciphertext_q)
`ifdef CT_STORE_CHECKSUM_EN
        ,
        .checksum_o  (checksum_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run-level model: a run is either accepting or not, and the word count alone fixes the write index.
    logic [TW-1:0] m_mem [MS];
    bit            m_known [MS];
    bit            m_active = 1'b0;
    bit            m_done = 1'b0;
    int            m_count = 0;
    logic [TW-1:0] m_chk = '0;
    logic [TW-1:0] m_q = '0;
    bit            m_q_known = 1'b0;

    task automatic check_outputs();
        check("ready", TW'(ct_ready_o), TW'(m_active));
        check("wr_addr", TW'(wr_addr_o), TW'(m_count % MS));
        check("count", TW'(count_o), TW'(m_count));
        check("done", TW'(done_o), TW'(m_done));
        if (m_q_known) check("rdata", ciphertext_q, m_q);
`ifdef CT_STORE_CHECKSUM_EN
        check("checksum", checksum_o, m_chk);
`endif
    endtask

    // Apply the current inputs for one clock edge, advance the model, then compare after the edge.
    task automatic tick();
        logic [TW-1:0] q_next;
        bit            q_known_next;
        int            ra;
        ra = int'(rd_addr_i);
        if (rst_i) begin
            q_next = '0;
            q_known_next = 1'b1;
        end else if (ra >= MS) begin
            q_next = '0;
            q_known_next = 1'b1;
        end else begin
            q_next = m_mem[ra];
            q_known_next = m_known[ra];
        end
        if (rst_i || clear_i) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_count  = 0;
            m_chk    = '0;
        end else if (!m_active) begin
            if (start_i) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_count  = 0;
                m_chk    = '0;
            end
        end else if (ct_valid_i) begin
            m_mem[m_count]   = ct_i;
            m_known[m_count] = 1'b1;
            m_chk            = m_chk ^ ct_i;
            m_count++;
            if (m_count == MS) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
        m_q       = q_next;
        m_q_known = q_known_next;
        check_outputs();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] old0;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        clear_i    = 1'b0;
        ct_valid_i = 1'b0;
        ct_i       = '0;
        rd_addr_i  = '0;
        for (int i = 0; i < MS; i++) m_known[i] = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_q", ciphertext_q, '0);

        // Full run of back-to-back words.
        pulse_start();
        for (int i = 0; i < MS; i++) begin
            ct_valid_i = 1'b1;
            ct_i       = TW'(32'h1000 + i);
            tick();
        end
        ct_valid_i = 1'b0;
        check("full_done", TW'(done_o), TW'(1));
        check("full_count", TW'(count_o), TW'(16));
        check("full_ready", TW'(ct_ready_o), TW'(0));
        check("full_wr_addr", TW'(wr_addr_o), TW'(0));
        rd_addr_i = AW'(5);
        tick();
        check("full_rd5", ciphertext_q, TW'(32'h1005));

        // Reset keeps memory; valid without start is ignored.
        rst_i = 1'b1;
        tick();
        tick();
        rst_i      = 1'b0;
        ct_valid_i = 1'b1;
        ct_i       = TW'(32'h5555);
        rd_addr_i  = '0;
        repeat (3) tick();
        ct_valid_i = 1'b0;
        check("idle_ready", TW'(ct_ready_o), TW'(0));
        check("idle_count", TW'(count_o), TW'(0));
        check("idle_rd0", ciphertext_q, TW'(32'h1000));

        // Valid on alternate cycles.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            ct_valid_i = 1'b1;
            ct_i       = TW'(8'hA0 + i);
            tick();
            ct_valid_i = 1'b0;
            tick();
        end
        check("gap_wr_addr", TW'(wr_addr_o), TW'(4));
        check("gap_count", TW'(count_o), TW'(4));
        for (int j = 0; j < 4; j++) begin
            rd_addr_i = AW'(j);
            tick();
            check("gap_rd", ciphertext_q, TW'(8'hA0 + j));
        end

        // Clear coincident with a handshake drops that word.
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            ct_valid_i = 1'b1;
            ct_i       = TW'(32'h2000 + i);
            tick();
        end
        clear_i = 1'b1;
        ct_i    = TW'(32'hDEAD);
        tick();
        clear_i    = 1'b0;
        ct_valid_i = 1'b0;
        check("clr_count", TW'(count_o), TW'(0));
        check("clr_ready", TW'(ct_ready_o), TW'(0));
        rd_addr_i = AW'(7);
        tick();
        check("clr_e7", ciphertext_q, TW'(32'h1007));

        // Restart from DONE with a same-address read/write collision.
        pulse_start();
        for (int i = 0; i < MS; i++) begin
            ct_valid_i = 1'b1;
            ct_i       = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        ct_valid_i = 1'b0;
        check("rs_done", TW'(done_o), TW'(1));
        old0 = m_mem[0];
        pulse_start();
        check("rs_done_clr", TW'(done_o), TW'(0));
        rd_addr_i  = '0;
        ct_valid_i = 1'b1;
        ct_i       = TW'(16'hBEEF);
        tick();
        ct_valid_i = 1'b0;
        check("rs_old", ciphertext_q, old0);
        tick();
        check("rs_new", ciphertext_q, TW'(16'hBEEF));

`ifdef CT_STORE_CHECKSUM_EN
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            ct_valid_i = 1'b1;
            ct_i       = (i == 0) ? TW'(8'h0F) : (i == 1) ? TW'(8'hF0) : TW'(8'hFF);
            tick();
        end
        ct_valid_i = 1'b0;
        check("chk_zero", checksum_o, '0);
        pulse_clear();
        check("chk_clr", checksum_o, '0);
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_i      = ($urandom_range(0, 299) == 0);
            clear_i    = ($urandom_range(0, 59) == 0);
            start_i    = ($urandom_range(0, 11) == 0);
            ct_valid_i = ($urandom_range(0, 2) != 0);
            ct_i       = {$urandom, $urandom, $urandom, $urandom};
            rd_addr_i  = AW'($urandom_range(0, (1 << AW) - 1));
            tick();
        end
        rst_i      = 1'b0;
        clear_i    = 1'b0;
        start_i    = 1'b0;
        ct_valid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ciphertext_store_memory.md
Name: ciphertext_store_memory

Overview:
- Write-side counterpart to the plaintext/key ROM: captures each 128-bit ciphertext produced by the AES encryption core and stores it at the same index as the plaintext it came from.
- Sits between the AES core output and the result-checking or readout logic.
- Provides a valid/ready write handshake, an address counter that mirrors the plaintext fetch index, a done flag, and a registered random-access read port.

Parameters:
- TEXT_WIDTH, 128, ciphertext word width in bits.
- ADDR_WIDTH, 4, address width of the store.
- MEMORY_SIZE, 16, number of entries; must be <= 2**ADDR_WIDTH.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle pulse; arms a new capture run.
- clear_i  input  1  synchronous abort; returns to IDLE, pointer to 0.
- ct_valid_i  input  1  ciphertext on ct_i is valid.
- ct_i  input  TEXT_WIDTH  ciphertext from the AES core.
- ct_ready_o  output  1  store accepts a word this cycle.
- wr_addr_o  output  ADDR_WIDTH  index the next accepted word is written to; aligns with plaintext pc.
- count_o  output  ADDR_WIDTH+1  number of words stored in the current run.
- done_o  output  1  all MEMORY_SIZE entries written.
- rd_addr_i  input  ADDR_WIDTH  read address.
- ciphertext_q  output  TEXT_WIDTH  registered read data.

Behaviour:
- States: IDLE, CAPTURE, DONE, held in a state register.
- Reset (rst_i=1 at an edge):
  - state=IDLE, wr_addr_o=0, count_o=0, done_o=0, ct_ready_o=0, ciphertext_q=0.
  - Memory contents are not cleared.
- ct_ready_o=1 exactly when state==CAPTURE; it is decoded from the state register only, with no combinational path from any input.
- IDLE:
  - start_i=1 -> CAPTURE; wr_addr_o and count_o are forced to 0.
  - ct_valid_i is ignored.
- CAPTURE:
  - On each edge with ct_valid_i&ct_ready_o: MEM[wr_addr_o]<=ct_i, wr_addr_o+1, count_o+1.
  - When the accepted word is at wr_addr_o==MEMORY_SIZE-1: next state DONE, done_o=1 from the following cycle, wr_addr_o wraps to 0, count_o=MEMORY_SIZE.
  - start_i is ignored while in CAPTURE.
- DONE:
  - Holds done_o=1, ct_ready_o=0; contents and count_o are frozen.
  - start_i=1 -> CAPTURE with wr_addr_o=0, count_o=0, done_o=0 (a new run overwrites the store).
- clear_i: in any state -> IDLE, wr_addr_o=0, count_o=0, done_o=0.
- Priority: rst_i > clear_i > start_i > write. With clear_i and a handshake in the same cycle, the word is NOT written.
- Read port:
  - ciphertext_q <= MEM[rd_addr_i] every cycle (1-cycle latency) in every state.
  - Read and write to the same address in the same cycle returns the old contents (read-before-write).
  - rd_addr_i >= MEMORY_SIZE returns all zeros.
- Back-to-back writes sustain one word per cycle; there is no bubble between accepted words.

Optional Feature:
- Macro: CT_STORE_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum_o, TEXT_WIDTH wide: running XOR of every word accepted in the current run.
  - Reset to 0 on rst_i, clear_i, and on start_i leaving IDLE or DONE.
  - Updated on the same edge as the memory write; value is valid the cycle after.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, then ct_valid_i=1 with no start -> ct_ready_o=0, count_o=0, done_o=0, no memory write (readback of addr 0 unchanged).
- Full run: start_i pulse, 16 back-to-back words ct_i=0x1000+i -> count_o reaches 16, done_o=1 the cycle after the 16th accept, ct_ready_o=0, wr_addr_o=0; reading addr 5 gives 0x1005 one cycle after rd_addr_i=5.
- Gapped valid: valid on alternate cycles for 4 words 0xA0..0xA3 -> wr_addr_o=4, count_o=4, entries 0..3 hold 0xA0..0xA3.
- Clear mid-run: after 7 accepts, clear_i coincident with a valid word 0xDEAD -> state IDLE, count_o=0, and entry 7 does not contain 0xDEAD.
- Restart from DONE plus read collision: in DONE, start_i, write 0xBEEF to addr 0 while rd_addr_i=0 -> ciphertext_q shows the old addr-0 value, then 0xBEEF on the next cycle; done_o clears.
- With CT_STORE_CHECKSUM_EN: write 0x0F, 0xF0, 0xFF -> checksum_o=0x00; after clear_i, checksum_o=0.
